// File: rtl/alu_chain_ctrl_pkg.sv
// Shared definitions for masters of the narrow ALU: opcode width, opcodes and
// the sequencer state encoding.
package alu_chain_ctrl_pkg;

  localparam int AC_N = 3;

  localparam logic [AC_N-1:0] AC_AD = 3'd0;
  localparam logic [AC_N-1:0] AC_SB = 3'd1;
  localparam logic [AC_N-1:0] AC_AN = 3'd2;
  localparam logic [AC_N-1:0] AC_OR = 3'd3;
  localparam logic [AC_N-1:0] AC_LS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only add and subtract report a meaningful chained carry/borrow.
  function automatic logic op_is_arith(input logic [AC_N-1:0] code);
    return (code == AC_AD) || (code == AC_SB);
  endfunction

endpackage

// File: rtl/alu_chain_ctrl.sv
// Wide-operation sequencer: runs an N*W-bit op as W slices on an external
// N-bit combinational ALU, LS word first, chaining carry/borrow between slices.
module alu_chain_ctrl
  import alu_chain_ctrl_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AC_N-1:0] op,
  input  logic [N*W-1:0]  a,
  input  logic [N*W-1:0]  b,
  input  logic            cin,
  output logic            busy,
  output logic            done,
  output logic [N*W-1:0]  result,
  output logic            zero,
  output logic            carry_out,
  output logic            err,
  output logic [AC_N-1:0] alu_cs,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic            alu_cin,
  input  logic [N-1:0]    alu_s,
  input  logic            alu_zero,
  input  logic            alu_cout
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_INDEX = IW'(W - 1);

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       index;
  logic [AC_N-1:0]     op_q;
  logic [W-1:0][N-1:0] a_q;
  logic [W-1:0][N-1:0] b_q;
  logic [W-1:0][N-1:0] res_q;
  logic [W-1:0][N-1:0] res_nxt;
  logic                cin_q;
  logic                carry_q;
  logic                carry_nxt;
  logic                err_nxt;
  logic                last;
  logic                accept;
  logic                unused_alu_zero;

  // The slice zero flag only covers one word; zero is rebuilt over the full result.
  assign unused_alu_zero = alu_zero;

  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);
  assign accept = start && !busy;
  assign last   = (index == LAST_INDEX);
  assign result = res_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Slice drive and the per-slice result/carry update; ALU bus is parked outside RUN.
  always_comb begin
    alu_cs    = AC_AD;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    res_nxt   = res_q;
    carry_nxt = carry_q;
    err_nxt   = err;
    if (state == ST_RUN) begin
      alu_a = a_q[index];
      alu_b = b_q[index];
      case (op_q)
        AC_AD, AC_SB: begin
          alu_cs         = op_q;
          alu_cin        = (index == '0) ? cin_q : carry_q;
          carry_nxt      = alu_cout;
          res_nxt[index] = alu_s;
        end
        AC_AN, AC_OR: begin
          alu_cs         = op_q;
          carry_nxt      = 1'b0;
          res_nxt[index] = alu_s;
        end
        AC_LS: begin
          // A<B is the final borrow of A-B; the difference words are thrown away.
          alu_cs    = AC_SB;
          alu_cin   = (index == '0) ? 1'b0 : carry_q;
          carry_nxt = alu_cout;
          if (last) res_nxt = {{(N*W-1){1'b0}}, alu_cout};
        end
        default: begin
          alu_cs    = op_q;
          carry_nxt = 1'b0;
          res_nxt   = '0;
          err_nxt   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      index     <= '0;
      op_q      <= AC_AD;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      res_q     <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= op;
        a_q     <= a;
        b_q     <= b;
        cin_q   <= cin;
        index   <= '0;
        carry_q <= 1'b0;
        err     <= 1'b0;
        res_q   <= '0;
      end else if (state == ST_RUN) begin
        res_q   <= res_nxt;
        carry_q <= carry_nxt;
        err     <= err_nxt;
        index   <= last ? '0 : index + 1'b1;
        if (last) begin
          zero      <= ~|res_nxt;
          carry_out <= op_is_arith(op_q) ? carry_nxt : 1'b0;
        end
      end
    end
  end

endmodule
